// File: rtl/regfile_sb.sv
// regfile_sb: register file with a per-register write-back scoreboard.
// Two combinational read ports, one synchronous write port, an optional
// hardwired-zero register 0 and an optional same-cycle write-to-read bypass.
// One busy bit per register tracks a single in-flight writer.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   wr_en, wr_addr, wr_data       write-back commit (writes data, releases busy)
//   rd_addr_a/b                   read addresses
//   rd_data_a/b, rd_busy_a/b      read data and pending-writer status (combinational)
//   iss_en, iss_addr              reserve a destination at issue
//   iss_ready                     iss_addr may be reserved this cycle (combinational)
//   flush                         drop all reservations
//   err                           sticky: an issue was rejected
module regfile_sb #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [WIDTH-1:0]  rd_data_a,
    output logic [WIDTH-1:0]  rd_data_b,
    output logic              rd_busy_a,
    output logic              rd_busy_b,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    output logic              iss_ready,
    input  logic              flush,
    output logic              err
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_next;
    logic             wr_eff;
    logic             iss_is_zero;
    logic             iss_take;
    logic             iss_reject;

    // A write to the hardwired zero register is discarded entirely.
    assign wr_eff      = wr_en && !(ZERO_REG && (wr_addr == '0));
    assign iss_is_zero = ZERO_REG && (iss_addr == '0);

    // Read port A: zero register, then bypass, then stored state.
    always_comb begin
        rd_data_a = mem[rd_addr_a];
        rd_busy_a = busy[rd_addr_a];
        if (ZERO_REG && (rd_addr_a == '0)) begin
            rd_data_a = '0;
            rd_busy_a = 1'b0;
        end else if (BYPASS && wr_eff && (wr_addr == rd_addr_a)) begin
            rd_data_a = wr_data;
            rd_busy_a = 1'b0;
        end
    end

    // Read port B: same priority as port A.
    always_comb begin
        rd_data_b = mem[rd_addr_b];
        rd_busy_b = busy[rd_addr_b];
        if (ZERO_REG && (rd_addr_b == '0)) begin
            rd_data_b = '0;
            rd_busy_b = 1'b0;
        end else if (BYPASS && wr_eff && (wr_addr == rd_addr_b)) begin
            rd_data_b = wr_data;
            rd_busy_b = 1'b0;
        end
    end

    // A busy destination becomes free early only when its writer commits now.
    assign iss_ready = iss_is_zero
                    || !busy[iss_addr]
                    || (BYPASS && wr_eff && (wr_addr == iss_addr));

    // flush suppresses both acceptance and rejection of a same-cycle issue.
    assign iss_take   = iss_en && iss_ready && !iss_is_zero && !flush;
    assign iss_reject = iss_en && !iss_ready && !flush;

    // Release from write-back first, so a same-cycle reservation wins.
    always_comb begin
        busy_next = busy;
        if (wr_eff) begin
            busy_next[wr_addr] = 1'b0;
        end
        if (flush) begin
            busy_next = '0;
        end else if (iss_take) begin
            busy_next[iss_addr] = 1'b1;
        end
    end

    // State update; reset overrides every other request.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            busy <= '0;
            err  <= 1'b0;
        end else begin
            if (wr_eff) begin
                mem[wr_addr] <= wr_data;
            end
            busy <= busy_next;
            if (iss_reject) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb (default parameters: ZERO_REG=1, BYPASS=1).
// Inputs are driven 1 time unit after each rising edge; outputs are sampled
// 1 time unit later, well before the next edge.
module tb_regfile_sb;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rd_addr_a;
    logic [4:0]  rd_addr_b;
    logic [31:0] rd_data_a;
    logic [31:0] rd_data_b;
    logic        rd_busy_a;
    logic        rd_busy_b;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic        iss_ready;
    logic        flush;
    logic        err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_data [32];
    logic        m_busy [32];
    logic        m_err;

    regfile_sb dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .rd_busy_a(rd_busy_a), .rd_busy_b(rd_busy_b),
        .iss_en(iss_en), .iss_addr(iss_addr), .iss_ready(iss_ready),
        .flush(flush), .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected read data for an address given current write inputs.
    function automatic logic [31:0] exp_data(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (wr_en && wr_addr == a) return wr_data;
        return m_data[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        if (wr_en && wr_addr == a) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic logic exp_ready(input logic [4:0] a);
        return (a == 5'd0) || !m_busy[a] || (wr_en && wr_addr == a);
    endfunction

    // Apply the current inputs to the model, then advance one clock edge.
    task automatic tick();
        logic rdy;
        rdy = exp_ready(iss_addr);
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_data[i] = 32'd0;
                m_busy[i] = 1'b0;
            end
            m_err = 1'b0;
        end else begin
            if (wr_en && wr_addr != 5'd0) begin
                m_data[wr_addr] = wr_data;
                m_busy[wr_addr] = 1'b0;
            end
            if (flush) begin
                for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
            end else if (iss_en) begin
                if (!rdy) m_err = 1'b1;
                else if (iss_addr != 5'd0) m_busy[iss_addr] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0; wr_en = 1'b0; iss_en = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        for (int i = 0; i < 32; i++) begin
            rd_addr_a = 5'(i); rd_addr_b = 5'(31 - i); iss_addr = 5'(i);
            #1;
            checks++;
            if (rd_data_a !== 32'd0 || rd_data_b !== 32'd0 || rd_busy_a !== 1'b0 ||
                rd_busy_b !== 1'b0 || iss_ready !== 1'b1 || err !== 1'b0) begin
                errors++;
                $display("FAIL reset addr=%0d got da=%h db=%h ba=%b bb=%b rdy=%b err=%b want 0,0,0,0,1,0",
                         i, rd_data_a, rd_data_b, rd_busy_a, rd_busy_b, iss_ready, err);
            end
        end
    endtask

    task automatic test_write_read();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        tick();
        rd_addr_a = 5'd5; rd_addr_b = 5'd5;
        #1;
        checks++;
        if (rd_data_a !== 32'hDEADBEEF || rd_data_b !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL write_x5 got a=%h b=%h want deadbeef", rd_data_a, rd_data_b);
        end
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
        tick();
        rd_addr_a = 5'd0;
        #1;
        checks++;
        if (rd_data_a !== 32'd0) begin
            errors++;
            $display("FAIL write_x0 got %h want 0", rd_data_a);
        end
    endtask

    task automatic test_bypass();
        iss_en = 1'b1; iss_addr = 5'd7;
        tick();
        rd_addr_a = 5'd7;
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5;
        #1;
        checks++;
        if (rd_data_a !== 32'hA5A5A5A5 || rd_busy_a !== 1'b0) begin
            errors++;
            $display("FAIL bypass_same got d=%h b=%b want a5a5a5a5 0", rd_data_a, rd_busy_a);
        end
        tick();
        #1;
        checks++;
        if (rd_data_a !== 32'hA5A5A5A5 || rd_busy_a !== 1'b0) begin
            errors++;
            $display("FAIL bypass_next got d=%h b=%b want a5a5a5a5 0", rd_data_a, rd_busy_a);
        end
    endtask

    task automatic test_hazard();
        iss_en = 1'b1; iss_addr = 5'd3;
        tick();
        rd_addr_a = 5'd3;
        #1;
        checks++;
        if (rd_busy_a !== 1'b1 || iss_ready !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL hazard_busy got b=%b rdy=%b err=%b want 1 0 0", rd_busy_a, iss_ready, err);
        end
        iss_en = 1'b1;
        tick();
        #1;
        checks++;
        if (err !== 1'b1 || rd_busy_a !== 1'b1) begin
            errors++;
            $display("FAIL hazard_err got err=%b b=%b want 1 1", err, rd_busy_a);
        end
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33;
        tick();
        #1;
        checks++;
        if (rd_busy_a !== 1'b0 || iss_ready !== 1'b1 || err !== 1'b1 || rd_data_a !== 32'h33) begin
            errors++;
            $display("FAIL hazard_release got b=%b rdy=%b err=%b d=%h want 0 1 1 33",
                     rd_busy_a, iss_ready, err, rd_data_a);
        end
        tick(); tick();
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky got %b want 1", err);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear got %b want 0", err);
        end
    endtask

    task automatic test_same_cycle();
        iss_en = 1'b1; iss_addr = 5'd9;
        tick();
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
        iss_en = 1'b1; iss_addr = 5'd9; rd_addr_b = 5'd9;
        #1;
        checks++;
        if (iss_ready !== 1'b1) begin
            errors++;
            $display("FAIL same_ready got %b want 1", iss_ready);
        end
        tick();
        #1;
        checks++;
        if (rd_busy_b !== 1'b1 || rd_data_b !== 32'h99 || err !== 1'b0) begin
            errors++;
            $display("FAIL same_commit got b=%b d=%h err=%b want 1 99 0", rd_busy_b, rd_data_b, err);
        end
    endtask

    task automatic test_flush();
        int bad;
        iss_en = 1'b1; iss_addr = 5'd1; tick();
        iss_en = 1'b1; iss_addr = 5'd2; tick();
        iss_en = 1'b1; iss_addr = 5'd4; tick();
        flush = 1'b1; iss_en = 1'b1; iss_addr = 5'd6;
        wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'h55;
        tick();
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            rd_addr_a = 5'(i);
            #1;
            if (rd_busy_a !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL flush_busy got %0d busy regs want 0", bad);
        end
        rd_addr_a = 5'd2;
        #1;
        checks++;
        if (rd_data_a !== 32'h55 || err !== 1'b0) begin
            errors++;
            $display("FAIL flush_write got d=%h err=%b want 55 0", rd_data_a, err);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            rst     = ($urandom_range(0, 99) == 0);
            flush   = ($urandom_range(0, 15) == 0);
            wr_en   = $urandom_range(0, 1) == 1;
            iss_en  = $urandom_range(0, 1) == 1;
            wr_data = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                wr_addr = 5'($urandom_range(0, 7));  rd_addr_a = 5'($urandom_range(0, 7));
                rd_addr_b = 5'($urandom_range(0, 7)); iss_addr = 5'($urandom_range(0, 7));
            end else begin
                wr_addr = 5'($urandom); rd_addr_a = 5'($urandom);
                rd_addr_b = 5'($urandom); iss_addr = 5'($urandom);
            end
            #1;
            checks++;
            if (rd_data_a !== exp_data(rd_addr_a) || rd_data_b !== exp_data(rd_addr_b) ||
                rd_busy_a !== exp_busy(rd_addr_a) || rd_busy_b !== exp_busy(rd_addr_b) ||
                iss_ready !== exp_ready(iss_addr) || err !== m_err) begin
                errors++;
                $display("FAIL random n=%0d got da=%h db=%h ba=%b bb=%b rdy=%b err=%b want %h %h %b %b %b %b",
                         n, rd_data_a, rd_data_b, rd_busy_a, rd_busy_b, iss_ready, err,
                         exp_data(rd_addr_a), exp_data(rd_addr_b), exp_busy(rd_addr_a),
                         exp_busy(rd_addr_b), exp_ready(iss_addr), m_err);
            end
            tick();
        end
    endtask

    initial begin
        rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr_a = '0; rd_addr_b = '0; iss_en = 1'b0; iss_addr = '0; flush = 1'b0;
        for (int i = 0; i < 32; i++) begin
            m_data[i] = 32'd0;
            m_busy[i] = 1'b0;
        end
        m_err = 1'b0;
        test_reset();
        test_write_read();
        test_bypass();
        test_hazard();
        test_same_cycle();
        test_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
